// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Shared funct codes, FSM encodings and decode helpers for the
//             bit-serial ALU sequencer and its 1-bit slice.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic logic is_supported(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR: is_supported = 1'b1;
`ifdef ALU_SERIAL_SEQ_SLT_EN
            FN_SLT:                        is_supported = 1'b1;
`endif
            default:                       is_supported = 1'b0;
        endcase
    endfunction

    // SLT is evaluated as a subtraction, so it shares the arithmetic path.
    function automatic logic is_arith(input logic [5:0] fn);
        is_arith = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
    endfunction

    function automatic logic inverts_b(input logic [5:0] fn);
        inverts_b = (fn == FN_SUB) || (fn == FN_SLT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_bit_slice.sv
// ============================================================================
//  Module   : alu_bit_slice
//  Brief    : Combinational 1-bit ALU slice (AND/OR/ADD/SUB); unsupported
//             selects produce zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [5:0] sel,
    output logic       out,
    output logic       cout
);

    logic w_b;

    always_comb begin
        w_b  = b ^ inverts_b(sel);
        out  = 1'b0;
        cout = 1'b0;
        case (sel)
            FN_AND: out = a & b;
            FN_OR:  out = a | b;
            default: begin
                if (is_arith(sel)) begin
                    out  = a ^ w_b ^ cin;
                    cout = (a & w_b) | (a & cin) | (w_b & cin);
                end
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial_seq.sv
// ============================================================================
//  Module   : alu_serial_seq
//  Brief    : Bit-serial sequencer driving one alu_bit_slice over WIDTH cycles,
//             valid/ready on both sides. Define ALU_SERIAL_SEQ_SLT_EN for SLT.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             illegal
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [5:0]       r_funct;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_bad;
    logic             r_carry_out;
    logic             r_zero;
    logic             r_illegal;

    logic             w_out;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    alu_bit_slice u_slice (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sel  (r_funct),
        .out  (w_out),
        .cout (w_cout)
    );

    // Operands and result shift right, so the slice always sees bit 0 and the
    // new sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_res_next = {w_out, r_result[WIDTH-1:1]};

`ifdef ALU_SERIAL_SEQ_SLT_EN
    logic w_slt;
    // Sign of A-B corrected by overflow: sum[MSB] ^ cin[MSB] ^ cout[MSB].
    assign w_slt = w_out ^ r_carry ^ w_cout;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_funct     <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_bad       <= 1'b0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a         <= op_a;
                        r_b         <= op_b;
                        r_funct     <= funct;
                        r_cnt       <= '0;
                        r_carry     <= inverts_b(funct);
                        r_bad       <= ~is_supported(funct);
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_zero      <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_state     <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (r_bad) begin
                        r_result    <= '0;
                        r_carry_out <= 1'b0;
                        r_zero      <= 1'b1;
                        r_illegal   <= 1'b1;
                        r_state     <= c_st_done;
                    end else begin
                        r_a      <= {1'b0, r_a[WIDTH-1:1]};
                        r_b      <= {1'b0, r_b[WIDTH-1:1]};
                        r_result <= w_res_next;
                        r_cnt    <= r_cnt + CNT_W'(1);
                        if (is_arith(r_funct)) begin
                            r_carry <= w_cout;
                        end
                        if (w_last) begin
                            r_state     <= c_st_done;
                            r_zero      <= (w_res_next == '0);
                            r_carry_out <= is_arith(r_funct) ? w_cout : 1'b0;
`ifdef ALU_SERIAL_SEQ_SLT_EN
                            if (r_funct == FN_SLT) begin
                                r_result    <= {{(WIDTH-1){1'b0}}, w_slt};
                                r_zero      <= ~w_slt;
                                r_carry_out <= 1'b0;
                            end
`endif
                        end
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

endmodule

`default_nettype wire
